// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Holds the operation encoding, the FSM state type and the iteration count.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor. Ports: rem, divisor, dbit -> rem_next, qbit.
module mips_cpu_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] divisor,
  input  logic        dbit,
  output logic [31:0] rem_next,
  output logic        qbit
);

  logic [32:0] shifted;
  logic [31:0] diff;

  assign shifted  = {rem, dbit};
  assign qbit     = (shifted >= {1'b0, divisor});
  // When the subtraction is taken the true difference fits in 32 bits.
  assign diff     = shifted[31:0] - divisor;
  assign rem_next = qbit ? diff : shifted[31:0];

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Ports: clk, rst_n, start/op/data_1/data_2, mthi/mtlo/wdata -> busy, done, hi, lo.
// Optional macro MIPS_CPU_MULDIV_FAST_MULT_EN: single-cycle multiplies.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state, state_n;
  muldiv_op_t    opc;

  logic [4:0]  cnt;
  logic [31:0] opa;
  logic [63:0] prod;
  logic [63:0] prod_next;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;

  logic        sgn;
  logic        div_in;
  logic        dz;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [32:0] mul_sum;
  logic [31:0] rem_next;
  logic        qbit;

  logic        launch;
  logic        fast;
  logic        fix;
  logic        fast_go;

  assign opc    = muldiv_op_t'(op);
  assign sgn    = (opc == OP_MULT) || (opc == OP_DIV);
  assign div_in = (opc == OP_DIV) || (opc == OP_DIVU);
  assign dz     = div_in && (data_2 == 32'd0);

  // Zero divisor keeps raw operands and no sign flags: the restoring
  // loop then yields quotient all-ones and remainder equal to data_1.
  assign x1 = (sgn && data_1[31] && !dz) ? -data_1 : data_1;
  assign x2 = (sgn && data_2[31] && !dz) ? -data_2 : data_2;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  logic [63:0] ext1;
  logic [63:0] ext2;
  logic [63:0] fast_prod;
  assign ext1      = {{32{sgn & data_1[31]}}, data_1};
  assign ext2      = {{32{sgn & data_2[31]}}, data_2};
  assign fast_prod = ext1 * ext2;
  assign fast_go   = start && !div_in;
`else
  assign fast_go   = 1'b0;
`endif

  assign mul_sum = {1'b0, prod[63:32]}
                 + (prod[0] ? {1'b0, opa} : 33'd0);

  mips_cpu_div_step u_step (
    .rem      (prod[63:32]),
    .divisor  (opa),
    .dbit     (prod[31]),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // Multiply shifts the product right; divide shifts quotient bits in
  // from the bottom while the remainder occupies the upper half.
  assign prod_next = is_div ? {rem_next, prod[30:0], qbit}
                            : {mul_sum, prod[31:1]};

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    fast    = 1'b0;
    fix     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (fast_go) begin
            fast = 1'b1;
          end else begin
            launch  = 1'b1;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == 5'(MULDIV_ITERS - 1)) state_n = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      opa    <= '0;
      prod   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        prod   <= {32'd0, div_in ? x1 : x2};
        opa    <= div_in ? x2 : x1;
        is_div <= div_in;
        neg_q  <= sgn && (data_1[31] ^ data_2[31]) && !dz;
        neg_r  <= sgn && div_in && data_1[31] && !dz;
        cnt    <= '0;
      end else if (fast) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
        {hi, lo} <= fast_prod;
`endif
        done <= 1'b1;
      end else if (state == IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
      if (state == RUN) begin
        prod <= prod_next;
        cnt  <= cnt + 5'd1;
      end
      if (fix) begin
        if (is_div) begin
          lo <= neg_q ? -prod[31:0]  : prod[31:0];
          hi <= neg_r ? -prod[63:32] : prod[63:32];
        end else begin
          {hi, lo} <= neg_q ? -prod : prod;
        end
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mips_cpu_muldiv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .data_1 (data_1),
    .data_2 (data_2),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el);
    longint sa, sb, sq, sr;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        u = 64'(sa * sb);
        eh = u[63:32]; el = u[31:0];
      end
      2'd1: begin
        u = {32'd0, a} * {32'd0, b};
        eh = u[63:32]; el = u[31:0];
      end
      2'd2: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFFFFFF;
        end else begin
          sq = sa / sb; sr = sa % sb;
          u = 64'(sq); el = u[31:0];
          u = 64'(sr); eh = u[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFFFFFF;
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] o);
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    return (o < 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; data_1 = a; data_2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n0);
    logic [31:0] eh, el;
    int n;
    bit fast;
    bit gap;
    model(o, a, b, eh, el);
    fast = is_fast(o);
    n = n0;
    gap = 1'b0;
    while (!done && n < 40) begin
      if (busy !== 1'b1) gap = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), fast ? 64'd0 : 64'd33);
    check("busy_hold", 64'(gap), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    launch(o, a, b);
    check("busy_e0", 64'(busy), is_fast(o) ? 64'd0 : 64'd1);
    finish(o, a, b, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0;
    data_1 = '0; data_2 = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(2'd0, 32'hFFFFFFFD, 32'd7);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2);
    run_op(2'd3, 32'd7, 32'd2);
    run_op(2'd3, 32'd100, 32'd0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(2'd2, 32'h12345, 32'd0);

    @(negedge clk);
    mthi = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi", 64'(hi), 64'h12345678);
    check("mthi_lo", 64'(lo), 64'(last_lo));
    check("mthi_done", 64'(done), 64'd0);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("both_hi", 64'(hi), 64'hCAFEF00D);
    check("both_lo", 64'(lo), 64'hCAFEF00D);

    @(negedge clk);
    start = 1'b1; op = 2'd3; data_1 = 32'd50; data_2 = 32'd7;
    mthi = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("start_wins", 64'(hi), 64'hCAFEF00D);
    finish(2'd3, 32'd50, 32'd7, 0);

    launch(2'd2, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    start = 1'b1; op = 2'd3; data_1 = 32'd100; data_2 = 32'd3;
    mtlo = 1'b1; wdata = 32'h55555555;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_busy", 64'(lo), 64'(last_lo));
    finish(2'd2, 32'hFFFFFFF9, 32'd2, 1);

    launch(2'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(2'd3, 32'd9, 32'd4);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
